ofs_fim_pcie_ss_rx_len_check: RTL



---
 rtl/ofs_fim_pcie_len_chk_pkg.sv | 24 ++
 rtl/ofs_fim_pcie_len_chk_popcnt.sv | 29 ++
 rtl/ofs_fim_pcie_ss_rx_len_check.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ofs_fim_pcie_len_chk_pkg.sv
// Shared types and header field positions for the PCIe RX payload length checker.
package ofs_fim_pcie_len_chk_pkg;

  typedef enum logic [1:0] {IDLE, CHECK, BYPASS} t_len_chk_state;

  localparam int FMT_TYPE_LSB = 24;
  localparam int HAS_DATA_BIT = 30;
  localparam int LEN_LSB      = 0;
  localparam int LEN_W        = 10;
  localparam int BCNT_W       = 13;

  // Byte totals pin at all-ones so a runaway TLP can never wrap back under the header length.
  function automatic logic [BCNT_W-1:0] bcnt_sat_add(input logic [BCNT_W-1:0] a,
                                                     input logic [BCNT_W-1:0] b);
    logic [BCNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[BCNT_W] ? {BCNT_W{1'b1}} : s[BCNT_W-1:0];
  endfunction

  function automatic logic [31:0] stat_sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ofs_fim_pcie_len_chk_popcnt.sv
// Combinational tkeep popcount built as a recursive binary adder tree; zero latency.
module ofs_fim_pcie_len_chk_popcnt #(
  parameter int W  = 64,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  keep,
  output logic [CW-1:0] cnt
);

  generate
    if (W == 1) begin : g_leaf
      assign cnt = CW'(keep);
    end else begin : g_split
      localparam int WL = W / 2;
      localparam int WH = W - WL;
      localparam int CL = $clog2(WL + 1);
      localparam int CH = $clog2(WH + 1);

      logic [CL-1:0] cnt_lo;
      logic [CH-1:0] cnt_hi;

      ofs_fim_pcie_len_chk_popcnt #(.W(WL), .CW(CL)) u_lo (.keep(keep[WL-1:0]), .cnt(cnt_lo));
      ofs_fim_pcie_len_chk_popcnt #(.W(WH), .CW(CH)) u_hi (.keep(keep[W-1:WL]), .cnt(cnt_hi));

      assign cnt = CW'(cnt_lo) + CW'(cnt_hi);
    end
  endgenerate

endmodule

// File: rtl/ofs_fim_pcie_ss_rx_len_check.sv
// Registered AXI-S pass-through (1 cycle, stalls only on out_tready) that flags TLPs whose payload
// length disagrees with the in-band header. OFS_FIM_PCIE_LEN_CHK_STATS_EN adds saturating counters.
module ofs_fim_pcie_ss_rx_len_check
  import ofs_fim_pcie_len_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int HDR_WIDTH  = 256,
  parameter int USER_W     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  input  logic [DATA_WIDTH-1:0]   in_tdata,
  input  logic [DATA_WIDTH/8-1:0] in_tkeep,
  input  logic                    in_tlast,
  input  logic [USER_W-1:0]       in_tuser_vendor,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic [DATA_WIDTH-1:0]   out_tdata,
  output logic [DATA_WIDTH/8-1:0] out_tkeep,
  output logic                    out_tlast,
  output logic [USER_W-1:0]       out_tuser_vendor,
  output logic                    out_err_short,
  output logic                    out_err_long
`ifdef OFS_FIM_PCIE_LEN_CHK_STATS_EN
  ,
  output logic [31:0]             stat_pkts,
  output logic [31:0]             stat_short,
  output logic [31:0]             stat_long
`endif
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int PC_W   = $clog2(KEEP_W + 1);
  localparam logic [BCNT_W-1:0] HDR_BYTES = BCNT_W'(HDR_WIDTH / 8);

  t_len_chk_state    state;
  logic              sop;
  logic [BCNT_W-1:0] bcnt;
  logic [BCNT_W-1:0] exp_q;

  logic              accept;
  logic [PC_W-1:0]   keep_cnt;
  logic [7:0]        fmt_type;
  logic [LEN_W-1:0]  len_dw;
  logic [BCNT_W-1:0] hdr_len, hdr_exp, kc, beat_bytes, total, exp_cur;
  logic              bypass, chk_short, chk_long;

  assign in_tready = !out_tvalid || out_tready;
  assign accept    = in_tvalid && in_tready;

  ofs_fim_pcie_len_chk_popcnt #(.W(KEEP_W), .CW(PC_W)) u_popcnt (
    .keep (in_tkeep),
    .cnt  (keep_cnt)
  );

  always_comb begin
    fmt_type   = in_tdata[FMT_TYPE_LSB +: 8];
    len_dw     = in_tdata[LEN_LSB +: LEN_W];
    hdr_len    = (len_dw == '0) ? BCNT_W'(4096) : BCNT_W'({len_dw, 2'b00});
    hdr_exp    = fmt_type[HAS_DATA_BIT - FMT_TYPE_LSB] ? hdr_len : '0;
    kc         = BCNT_W'(keep_cnt);
    // Header bytes of the SOP beat are not payload; a short SOP beat contributes nothing.
    beat_bytes = kc;
    if (sop) beat_bytes = (kc > HDR_BYTES) ? kc - HDR_BYTES : '0;
    total      = bcnt_sat_add(sop ? '0 : bcnt, beat_bytes);
    exp_cur    = sop ? hdr_exp : exp_q;
    bypass     = sop ? in_tuser_vendor[0] : (state == BYPASS);
    chk_short  = in_tlast && !bypass && (total < exp_cur);
    chk_long   = in_tlast && !bypass && (total > exp_cur);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      sop           <= 1'b1;
      bcnt          <= '0;
      exp_q         <= '0;
      out_tvalid    <= 1'b0;
      out_err_short <= 1'b0;
      out_err_long  <= 1'b0;
    end else begin
      if (in_tready) begin
        out_tvalid    <= in_tvalid;
        out_err_short <= accept && chk_short;
        out_err_long  <= accept && chk_long;
      end
      if (accept) begin
        sop  <= in_tlast;
        bcnt <= in_tlast ? '0 : total;
        if (sop) exp_q <= hdr_exp;
        if (in_tlast)  state <= IDLE;
        else if (sop)  state <= in_tuser_vendor[0] ? BYPASS : CHECK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      out_tdata        <= in_tdata;
      out_tkeep        <= in_tkeep;
      out_tlast        <= in_tlast;
      out_tuser_vendor <= in_tuser_vendor;
    end
  end

`ifdef OFS_FIM_PCIE_LEN_CHK_STATS_EN
  logic out_eop;
  assign out_eop = out_tvalid && out_tready && out_tlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pkts  <= '0;
      stat_short <= '0;
      stat_long  <= '0;
    end else if (out_eop) begin
      stat_pkts <= stat_sat_inc(stat_pkts);
      if (out_err_short) stat_short <= stat_sat_inc(stat_short);
      if (out_err_long)  stat_long  <= stat_sat_inc(stat_long);
    end
  end
`endif

endmodule
